// File: rtl/stack_unit.sv
// LIFO stack on a register array with an internal stack pointer, replace-top,
// clear, indexed peek and sticky overflow/underflow flags.
module stack_unit #(
  parameter int DATA_WIDTH = 12,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  push,
  input  logic                  pop,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  peek_req,
  input  logic [ADDR_WIDTH-1:0] peek_offset,
  output logic [DATA_WIDTH-1:0] top_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic [DATA_WIDTH-1:0] peek_data,
  output logic                  peek_valid,
  output logic                  peek_hit
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0]   C_ZERO = '0;
  localparam logic [ADDR_WIDTH:0]   C_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   C_FULL = DEPTH;
  localparam logic [ADDR_WIDTH-1:0] A_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] A_TWO  = 2;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH:0]   r_count;
  logic [DATA_WIDTH-1:0] r_top;
  logic                  r_ovf;
  logic                  r_udf;
  logic [DATA_WIDTH-1:0] r_peek_data;
  logic                  r_peek_valid;
  logic                  r_peek_hit;

  logic                  w_empty;
  logic                  w_full;
  logic [ADDR_WIDTH-1:0] w_idx_cnt;
  logic [ADDR_WIDTH-1:0] w_idx_m1;
  logic [ADDR_WIDTH-1:0] w_idx_m2;
  logic [ADDR_WIDTH-1:0] w_peek_idx;
  logic                  w_peek_in;
  logic                  w_replace;
  logic                  w_wr_en;
  logic [ADDR_WIDTH-1:0] w_wr_idx;

  assign w_empty    = (r_count == C_ZERO);
  assign w_full     = (r_count == C_FULL);
  assign w_idx_cnt  = r_count[ADDR_WIDTH-1:0];
  assign w_idx_m1   = w_idx_cnt - A_ONE;
  assign w_idx_m2   = w_idx_cnt - A_TWO;
  assign w_peek_idx = w_idx_m1 - peek_offset;
  assign w_peek_in  = ({1'b0, peek_offset} < r_count);

  // push+pop on an empty stack degrades to a plain push
  assign w_replace = push && pop && !w_empty;
  assign w_wr_en   = reset_n && !clear && push && (w_replace || !w_full);
  assign w_wr_idx  = w_replace ? w_idx_m1 : w_idx_cnt;

  always_ff @(posedge clock) begin
    if (w_wr_en) r_mem[w_wr_idx] <= push_data;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_count      <= '0;
      r_top        <= '0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_peek_data  <= '0;
      r_peek_valid <= 1'b0;
      r_peek_hit   <= 1'b0;
    end else if (clear) begin
      r_count      <= '0;
      r_top        <= '0;
      r_ovf        <= 1'b0;
      r_udf        <= 1'b0;
      r_peek_valid <= 1'b0;
    end else begin
      if (w_replace) begin
        r_top <= push_data;
      end else if (push) begin
        if (w_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_count <= r_count + C_ONE;
          r_top   <= push_data;
        end
      end else if (pop) begin
        if (w_empty) begin
          r_udf <= 1'b1;
        end else if (r_count == C_ONE) begin
          r_count <= '0;
          r_top   <= '0;
        end else begin
          r_count <= r_count - C_ONE;
          r_top   <= r_mem[w_idx_m2];
        end
      end

      // peek reads pre-edge count and array contents
      r_peek_valid <= peek_req;
      if (peek_req) begin
        r_peek_hit  <= w_peek_in;
        r_peek_data <= w_peek_in ? r_mem[w_peek_idx] : '0;
      end
    end
  end

  assign top_data   = r_top;
  assign count      = r_count;
  assign empty      = w_empty;
  assign full       = w_full;
  assign overflow   = r_ovf;
  assign underflow  = r_udf;
  assign peek_data  = r_peek_data;
  assign peek_valid = r_peek_valid;
  assign peek_hit   = r_peek_hit;

endmodule

// File: tb/tb_stack_unit.sv
// Directed bench for stack_unit at DATA_WIDTH=12, ADDR_WIDTH=2.
module tb_stack_unit;

  localparam int DW = 12;
  localparam int AW = 2;

  logic          clock = 1'b0;
  logic          reset_n, push, pop, clear, peek_req;
  logic [DW-1:0] push_data;
  logic [AW-1:0] peek_offset;
  logic [DW-1:0] top_data, peek_data;
  logic [AW:0]   count;
  logic          empty, full, overflow, underflow, peek_valid, peek_hit;

  int n_checks = 0;
  int n_pass   = 0;

  stack_unit #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock(clock), .reset_n(reset_n), .push(push), .pop(pop), .clear(clear),
    .push_data(push_data), .peek_req(peek_req), .peek_offset(peek_offset),
    .top_data(top_data), .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow), .peek_data(peek_data),
    .peek_valid(peek_valid), .peek_hit(peek_hit)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    push = 0; pop = 0; clear = 0; peek_req = 0; reset_n = 1;
  endtask

  task automatic do_push(input logic [DW-1:0] d);
    push = 1; push_data = d;
    step();
    idle();
  endtask

  task automatic test_reset();
    idle(); reset_n = 0;
    step();
    idle();
    n_checks++;
    if ({count, top_data, empty, full, overflow, underflow} !== {3'd0, 12'h000, 1'b1, 1'b0, 1'b0, 1'b0})
      $display("FAIL reset_state got cnt=%0d top=%h e=%b f=%b ov=%b un=%b want 0 000 1 0 0 0",
               count, top_data, empty, full, overflow, underflow);
    else n_pass++;
    n_checks++;
    if ({peek_data, peek_valid, peek_hit} !== {12'h000, 1'b0, 1'b0})
      $display("FAIL reset_peek got data=%h v=%b h=%b want 000 0 0", peek_data, peek_valid, peek_hit);
    else n_pass++;
  endtask

  task automatic test_push();
    do_push(12'h011); do_push(12'h022); do_push(12'h033);
    n_checks++;
    if ({count, top_data, empty, full} !== {3'd3, 12'h033, 1'b0, 1'b0})
      $display("FAIL push3 got cnt=%0d top=%h e=%b f=%b want 3 033 0 0", count, top_data, empty, full);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_push(12'h044);
    n_checks++;
    if ({count, full} !== {3'd4, 1'b1})
      $display("FAIL push_full got cnt=%0d f=%b want 4 1", count, full);
    else n_pass++;
    do_push(12'h055);
    n_checks++;
    if ({count, top_data, overflow} !== {3'd4, 12'h044, 1'b1})
      $display("FAIL overflow got cnt=%0d top=%h ov=%b want 4 044 1", count, top_data, overflow);
    else n_pass++;
    pop = 1; step(); idle();
    n_checks++;
    if ({count, top_data, overflow, full} !== {3'd3, 12'h033, 1'b1, 1'b0})
      $display("FAIL ovf_sticky got cnt=%0d top=%h ov=%b f=%b want 3 033 1 0", count, top_data, overflow, full);
    else n_pass++;
    clear = 1; step(); idle();
    n_checks++;
    if ({count, overflow, empty} !== {3'd0, 1'b0, 1'b1})
      $display("FAIL ovf_clear got cnt=%0d ov=%b e=%b want 0 0 1", count, overflow, empty);
    else n_pass++;
  endtask

  task automatic test_push_pop();
    do_push(12'h011); do_push(12'h022);
    push = 1; pop = 1; push_data = 12'h099; step(); idle();
    n_checks++;
    if ({count, top_data, overflow, underflow} !== {3'd2, 12'h099, 1'b0, 1'b0})
      $display("FAIL replace got cnt=%0d top=%h ov=%b un=%b want 2 099 0 0", count, top_data, overflow, underflow);
    else n_pass++;
    pop = 1; step(); idle();
    n_checks++;
    if ({count, top_data} !== {3'd1, 12'h011})
      $display("FAIL pop2 got cnt=%0d top=%h want 1 011", count, top_data);
    else n_pass++;
    pop = 1; step(); idle();
    n_checks++;
    if ({count, top_data, empty, underflow} !== {3'd0, 12'h000, 1'b1, 1'b0})
      $display("FAIL pop_last got cnt=%0d top=%h e=%b un=%b want 0 000 1 0", count, top_data, empty, underflow);
    else n_pass++;
    pop = 1; step(); idle();
    n_checks++;
    if ({count, underflow} !== {3'd0, 1'b1})
      $display("FAIL underflow got cnt=%0d un=%b want 0 1", count, underflow);
    else n_pass++;
    clear = 1; step(); idle();
    n_checks++;
    if (underflow !== 1'b0)
      $display("FAIL udf_clear got un=%b want 0", underflow);
    else n_pass++;
  endtask

  task automatic test_empty_push_pop();
    push = 1; pop = 1; push_data = 12'h007; step(); idle();
    n_checks++;
    if ({count, top_data, underflow} !== {3'd1, 12'h007, 1'b0})
      $display("FAIL empty_replace got cnt=%0d top=%h un=%b want 1 007 0", count, top_data, underflow);
    else n_pass++;
    clear = 1; step(); idle();
  endtask

  task automatic test_peek();
    do_push(12'h011); do_push(12'h022); do_push(12'h033);
    peek_req = 1; peek_offset = 2'd0; step();
    n_checks++;
    if ({peek_valid, peek_hit, peek_data} !== {1'b1, 1'b1, 12'h033})
      $display("FAIL peek0 got v=%b h=%b d=%h want 1 1 033", peek_valid, peek_hit, peek_data);
    else n_pass++;
    peek_offset = 2'd2; step();
    n_checks++;
    if ({peek_valid, peek_hit, peek_data} !== {1'b1, 1'b1, 12'h011})
      $display("FAIL peek2 got v=%b h=%b d=%h want 1 1 011", peek_valid, peek_hit, peek_data);
    else n_pass++;
    peek_offset = 2'd3; step();
    idle();
    n_checks++;
    if ({peek_valid, peek_hit, peek_data} !== {1'b1, 1'b0, 12'h000})
      $display("FAIL peek3_miss got v=%b h=%b d=%h want 1 0 000", peek_valid, peek_hit, peek_data);
    else n_pass++;
    step();
    n_checks++;
    if ({peek_valid, peek_hit, peek_data} !== {1'b0, 1'b0, 12'h000})
      $display("FAIL peek_idle got v=%b h=%b d=%h want 0 0 000", peek_valid, peek_hit, peek_data);
    else n_pass++;
    peek_req = 1; peek_offset = 2'd0; push = 1; push_data = 12'h044; step(); idle();
    n_checks++;
    if ({peek_valid, peek_hit, peek_data, count, top_data} !== {1'b1, 1'b1, 12'h033, 3'd4, 12'h044})
      $display("FAIL peek_push got v=%b h=%b d=%h cnt=%0d top=%h want 1 1 033 4 044",
               peek_valid, peek_hit, peek_data, count, top_data);
    else n_pass++;
    peek_req = 1; peek_offset = 2'd0; step(); idle();
    n_checks++;
    if (peek_data !== 12'h044)
      $display("FAIL peek_after_push got d=%h want 044", peek_data);
    else n_pass++;
  endtask

  task automatic test_clear_reset();
    do_push(12'h055);
    pop = 1; step(); idle();
    peek_req = 1; peek_offset = 2'd0; step(); idle();
    n_checks++;
    if ({count, overflow, peek_data, peek_hit} !== {3'd3, 1'b1, 12'h033, 1'b1})
      $display("FAIL pre_clear got cnt=%0d ov=%b d=%h h=%b want 3 1 033 1", count, overflow, peek_data, peek_hit);
    else n_pass++;
    clear = 1; push = 1; push_data = 12'h066; peek_req = 1; peek_offset = 2'd1; step(); idle();
    n_checks++;
    if ({count, top_data, overflow, underflow, empty, peek_valid} !== {3'd0, 12'h000, 1'b0, 1'b0, 1'b1, 1'b0})
      $display("FAIL clear_push got cnt=%0d top=%h ov=%b un=%b e=%b v=%b want 0 000 0 0 1 0",
               count, top_data, overflow, underflow, empty, peek_valid);
    else n_pass++;
    n_checks++;
    if ({peek_data, peek_hit} !== {12'h033, 1'b1})
      $display("FAIL clear_peek_hold got d=%h h=%b want 033 1", peek_data, peek_hit);
    else n_pass++;
    do_push(12'h012);
    pop = 1; step(); pop = 1; step(); idle();
    n_checks++;
    if (underflow !== 1'b1)
      $display("FAIL pre_reset_un got un=%b want 1", underflow);
    else n_pass++;
    do_push(12'h013);
    reset_n = 0; pop = 1; peek_req = 1; peek_offset = 2'd0; step(); idle();
    n_checks++;
    if ({count, top_data, overflow, underflow, peek_valid, peek_hit, peek_data}
        !== {3'd0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000})
      $display("FAIL reset_pop got cnt=%0d top=%h ov=%b un=%b v=%b h=%b d=%h want 0 000 0 0 0 0 000",
               count, top_data, overflow, underflow, peek_valid, peek_hit, peek_data);
    else n_pass++;
  endtask

  initial begin
    idle(); push_data = '0; peek_offset = '0;
    @(negedge clock);
    test_reset();
    test_push();
    test_overflow();
    test_push_pop();
    test_empty_push_pop();
    test_peek();
    test_clear_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/stack_unit.md
Name: stack_unit

Overview:
- Parametrised LIFO stack built on a register-array memory; generalises the single-port stack memory.
- Owns its own stack pointer and supports push, pop, push+pop (replace top), clear and indexed peek.
- Provides full/empty status and sticky overflow/underflow error flags.
- Sits between the expression/evaluation datapath and its operand storage; callers never manage addresses.

Parameters:
- DATA_WIDTH, 12, width of each stack entry.
- ADDR_WIDTH, 8, log2 of depth; DEPTH = 1<<ADDR_WIDTH entries.

Ports:
- clock  in  1  rising-edge clock for all state.
- reset_n  in  1  synchronous active-low reset.
- push  in  1  push push_data this cycle.
- pop  in  1  pop the top entry this cycle.
- clear  in  1  synchronous empty-the-stack command.
- push_data  in  DATA_WIDTH  data to push.
- peek_req  in  1  request a read at peek_offset.
- peek_offset  in  ADDR_WIDTH  depth below top; 0 = top.
- top_data  out  DATA_WIDTH  registered current top entry; 0 when empty.
- count  out  ADDR_WIDTH+1  number of stored entries, 0..DEPTH.
- empty  out  1  count==0.
- full  out  1  count==DEPTH.
- overflow  out  1  sticky: push attempted while full without pop.
- underflow  out  1  sticky: pop attempted while empty without push.
- peek_data  out  DATA_WIDTH  peek result.
- peek_valid  out  1  one-cycle pulse: peek_data is valid.
- peek_hit  out  1  qualifies peek_valid: offset was below count.

Behaviour:
- Reset (reset_n=0 at posedge):
  - count=0, top_data=0, overflow=0, underflow=0.
  - peek_data=0, peek_valid=0, peek_hit=0.
  - empty=1, full=0.
  - Array contents are not reset.
- Priority at each posedge: reset_n low > clear > push/pop. clear behaves as reset but leaves peek outputs unaffected except that peek_valid drops to 0.
- Operations, decoded with count sampled at the edge (all results visible the cycle after the edge):
  - push only, not full: mem[count]<=push_data; count+1; top_data<=push_data.
  - push only, full: no write; count unchanged; overflow<=1.
  - pop only, count>1: count-1; top_data<=mem[count-2].
  - pop only, count==1: count<=0; top_data<=0.
  - pop only, empty: no change; underflow<=1.
  - push+pop, not empty: mem[count-1]<=push_data; count unchanged; top_data<=push_data; no flag even when full.
  - push+pop, empty: treated as push only; underflow is not set.
  - neither: hold.
- Status outputs:
  - empty and full are combinational decodes of the count register.
  - overflow and underflow remain set until clear or reset.
- Peek:
  - peek_req sampled at the edge, using count and array contents from before any same-edge push/pop/write.
  - Next cycle: peek_valid=1 for exactly one cycle.
  - If peek_offset<count: peek_hit=1, peek_data=mem[count-1-peek_offset].
  - Otherwise: peek_hit=0, peek_data=0.
  - Back-to-back peek_req gives back-to-back results with 1-cycle latency.
  - When there is no peek_req, peek_data holds its last value and peek_hit holds.
- Arithmetic:
  - count is ADDR_WIDTH+1 bits and never wraps; saturation comes from the full/empty rules above.
  - Array indices use the low ADDR_WIDTH bits.
- Reset or clear mid-operation: any same-cycle push, pop or peek is discarded.

Test Plan:
- ADDR_WIDTH=2. Reset, push 0x11, 0x22, 0x33 on consecutive cycles -> count=3, top_data=0x33, empty=0, full=0.
- From count=3, push 0x44 -> full=1. Push 0x55 -> count stays 4, top_data=0x44, overflow=1. Later pop -> overflow stays 1 until clear.
- Stack [0x11,0x22]: push+pop with 0x99 -> count=2, top_data=0x99. Pop -> top_data=0x11. Pop -> top_data=0, empty=1. Pop -> underflow=1.
- Empty stack: push+pop with 0x07 -> count=1, top_data=0x07, underflow=0.
- Stack [0x11,0x22,0x33]: peek offsets 0,2,3 back-to-back -> peek_valid on the next 3 cycles with (0x33,hit=1), (0x11,hit=1), (0,hit=0).
  - Peek offset 0 in the same cycle as push 0x44 -> returns 0x33.
- Stack at count=3 with overflow=1: assert clear together with push -> count=0, flags=0, top_data=0, no write.
  - Assert reset_n=0 together with pop -> same cleared state, and peek_valid=0.
